xframegen: RTL and testbench
============================

Name: xframegen

Overview:
- Frame generator that reads a block of samples from a synchronous single-port RAM read port.
- Emits the samples as a framed serial stream (data, nd, head, tail) for serial-frame consumers such as the max/min search, FFT front-ends and statistics blocks.
- Frame base address, length and inter-sample gap are set per frame by a one-cycle start pulse.

Parameters:
BWID, 16, sample data width
BWID_INDEX, 10, width of frame length and sample index
BWID_ADDR, 10, RAM address width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
i_start  input  1  one-cycle frame start request
iv_baseaddr  input  BWID_ADDR  RAM address of sample 0, latched at accepted start
iv_len  input  BWID_INDEX  number of samples in frame, latched at accepted start
iv_gap  input  8  idle cycles between consecutive samples, latched at accepted start
o_rden  output  1  RAM read enable
ov_rdaddr  output  BWID_ADDR  RAM read address
iv_rddata  input  BWID  RAM read data, valid the cycle after o_rden
ov_data  output  BWID  serial data out
o_nd  output  1  ov_data valid
o_head  output  1  first sample of frame, only with o_nd
o_tail  output  1  last sample of frame, only with o_nd
ov_index  output  BWID_INDEX  index of current sample, 0..len-1
o_busy  output  1  frame in progress
o_done  output  1  one-cycle pulse, the cycle after o_tail
o_err  output  1  one-cycle pulse, start rejected

Behaviour:
- Reset: synchronous and active-high. All outputs register to 0. FSM goes to IDLE and internal counters clear.
- Reset mid-frame: the frame is aborted and no tail is emitted. The block is idle the cycle after rst and accepts i_start the cycle after rst deasserts.
- FSM states: IDLE, READ, GAP, DRAIN.
- IDLE:
  - i_start=1 with iv_len>=2: latch base, len and gap, clear read counter k=0, set o_busy=1, go to READ.
  - i_start=1 with iv_len<2: pulse o_err for one cycle and stay in IDLE. Downstream consumers require distinct head and tail beats.
- READ:
  - Drive o_rden=1 and ov_rdaddr=base+k, modulo 2^BWID_ADDR (address wraps).
  - If k=len-1, go to DRAIN.
  - Otherwise k++; go to GAP if gap>0, else stay in READ.
- GAP: count gap cycles with o_rden=0, then go to READ.
- DRAIN: wait for the last sample to leave the output stage, then pulse o_done, clear o_busy, go to IDLE.
- Data path pipeline:
  - A read issued in cycle C returns iv_rddata in cycle C+1.
  - ov_data, o_nd, o_head, o_tail and ov_index are registered and valid in cycle C+2.
  - Read-side flags (first, last, index) are delayed two stages alongside the data.
- Timing: i_start high in cycle 0 gives o_rden in cycle 1 and the first o_nd with o_head in cycle 3.
- Beat spacing: samples are spaced gap+1 cycles apart. Sample i has o_nd in cycle 3+i*(gap+1).
- Tail and completion: o_tail is in cycle 3+(len-1)*(gap+1). o_done and the o_busy fall occur in the following cycle.
- Output values when idle:
  - o_nd, o_head, o_tail are 0 whenever no beat is valid.
  - ov_data holds its last value.
  - ov_index is 0 when idle.
- o_head and o_tail are never high in the same cycle.
- i_start while o_busy=1 is ignored: no error, no effect on the current frame.
- i_start in the same cycle as the o_done pulse is accepted, so back-to-back frames are allowed.
- Latched parameters are stable for the whole frame. Input changes during a frame have no effect.
- len counts up to 2^BWID_INDEX-1. The index counter never wraps within a frame.

Test Plan:
1. RAM[a]=3*a; start with base=0x010, len=4, gap=0 -> o_rden in cycles 1-4 with addrs 0x010-0x013; o_nd in cycles 3-6 with data 0x30,0x33,0x36,0x39; o_head in cycle 3; o_tail in cycle 6; o_done in cycle 7; ov_index 0..3.
2. base=0x020, len=3, gap=2 -> o_nd in cycles 3, 6, 9 only; o_tail in cycle 9; o_rden never high in GAP cycles.
3. len=1, then len=0 -> o_err pulse in cycle 1 each time; o_rden, o_nd and o_busy stay 0.
4. base=0x3FE, len=4 -> ov_rdaddr sequence 0x3FE, 0x3FF, 0x000, 0x001; data follows RAM contents.
5. len=8, gap=0, rst high in cycle 5 -> all outputs 0 from cycle 6; no o_tail and no o_done; a new start after rst runs a clean full frame.
6. i_start re-asserted in cycles 2 and 4 of a len=4 frame -> ignored; a single frame results. A start coincident with o_done -> second frame o_head 3 cycles later. Connect to the max/min search and check ov_total=4 and correct max/min.

Source files
------------

// File: rtl/xframegen.sv
// Frame generator: reads len samples from a synchronous RAM starting at a base
// address and emits them as a framed serial stream (data, nd, head, tail, index).
module xframegen #(
    parameter int BWID       = 16,
    parameter int BWID_INDEX = 10,
    parameter int BWID_ADDR  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [BWID_ADDR-1:0]  iv_baseaddr,
    input  logic [BWID_INDEX-1:0] iv_len,
    input  logic [7:0]            iv_gap,
    output logic                  o_rden,
    output logic [BWID_ADDR-1:0]  ov_rdaddr,
    input  logic [BWID-1:0]       iv_rddata,
    output logic [BWID-1:0]       ov_data,
    output logic                  o_nd,
    output logic                  o_head,
    output logic                  o_tail,
    output logic [BWID_INDEX-1:0] ov_index,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [1:0]            dbg_state
);

    // Output stream: o_nd qualifies ov_data/o_head/o_tail/ov_index for exactly one
    // cycle. There is no backpressure; a consumer must take every beat it sees.
    typedef enum logic [1:0] {IDLE, READ, GAP, DRAIN} state_t;

    state_t                state;
    logic [BWID_ADDR-1:0]  base_r;
    logic [BWID_INDEX-1:0] len_m1;
    logic [7:0]            gap_r;
    logic [7:0]            gap_cnt;
    logic [BWID_INDEX-1:0] k;
    logic [BWID_INDEX-1:0] k_next;

    // Stage 1 flags travel with the RAM read latency
    logic                  rd_v1;
    logic                  first1;
    logic                  last1;
    logic [BWID_INDEX-1:0] idx1;

    assign k_next    = k + 1'b1;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_r    <= '0;
            len_m1    <= '0;
            gap_r     <= '0;
            gap_cnt   <= '0;
            k         <= '0;
            rd_v1     <= 1'b0;
            first1    <= 1'b0;
            last1     <= 1'b0;
            idx1      <= '0;
            o_rden    <= 1'b0;
            ov_rdaddr <= '0;
            ov_data   <= '0;
            o_nd      <= 1'b0;
            o_head    <= 1'b0;
            o_tail    <= 1'b0;
            ov_index  <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;

            rd_v1  <= o_rden;
            first1 <= o_rden && (k == '0);
            last1  <= o_rden && (k == len_m1);
            idx1   <= k;

            o_nd     <= rd_v1;
            o_head   <= rd_v1 && first1;
            o_tail   <= rd_v1 && last1;
            ov_index <= rd_v1 ? idx1 : '0;
            if (rd_v1) begin
                ov_data <= iv_rddata;
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        // Single-beat frames are rejected: head and tail must be distinct beats
                        if (iv_len >= BWID_INDEX'(2)) begin
                            base_r    <= iv_baseaddr;
                            len_m1    <= iv_len - 1'b1;
                            gap_r     <= iv_gap;
                            k         <= '0;
                            o_busy    <= 1'b1;
                            o_rden    <= 1'b1;
                            ov_rdaddr <= iv_baseaddr;
                            state     <= READ;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (k == len_m1) begin
                        o_rden <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        k <= k_next;
                        if (gap_r != 8'd0) begin
                            o_rden  <= 1'b0;
                            gap_cnt <= gap_r - 8'd1;
                            state   <= GAP;
                        end else begin
                            o_rden    <= 1'b1;
                            ov_rdaddr <= base_r + BWID_ADDR'(k_next);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        o_rden    <= 1'b1;
                        ov_rdaddr <= base_r + BWID_ADDR'(k);
                        state     <= READ;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                DRAIN: begin
                    // The tail beat is on the output this cycle; completion follows it
                    if (o_tail) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xframegen.sv
// Directed bench for xframegen: a RAM model holding 3*addr, expected reads and
// beats queued at each start, checked by a negedge monitor.
module tb_xframegen;

    localparam int BWID       = 16;
    localparam int BWID_INDEX = 10;
    localparam int BWID_ADDR  = 10;
    localparam int NEVER      = 1000000;

    typedef struct {
        int          cyc;
        int          total;
        logic [15:0] mx;
        logic [15:0] mn;
    } stat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  i_start = 1'b0;
    logic [BWID_ADDR-1:0]  iv_baseaddr = '0;
    logic [BWID_INDEX-1:0] iv_len = '0;
    logic [7:0]            iv_gap = '0;
    logic                  o_rden;
    logic [BWID_ADDR-1:0]  ov_rdaddr;
    logic [BWID-1:0]       iv_rddata = '0;
    logic [BWID-1:0]       ov_data;
    logic                  o_nd;
    logic                  o_head;
    logic                  o_tail;
    logic [BWID_INDEX-1:0] ov_index;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;
    logic [1:0]            dbg_state;

    logic [BWID-1:0] mem [0:(1<<BWID_ADDR)-1];

    logic [41:0] rd_q[$];
    logic [59:0] beat_q[$];
    int          done_q[$];
    int          err_q[$];
    logic [32:0] busy_q[$];
    int          zero_q[$];
    stat_t       stat_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic finish_req = 1'b0;
    logic report_done = 1'b0;

    xframegen #(
        .BWID(BWID), .BWID_INDEX(BWID_INDEX), .BWID_ADDR(BWID_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .iv_baseaddr(iv_baseaddr), .iv_len(iv_len), .iv_gap(iv_gap),
        .o_rden(o_rden), .ov_rdaddr(ov_rdaddr), .iv_rddata(iv_rddata),
        .ov_data(ov_data), .o_nd(o_nd), .o_head(o_head), .o_tail(o_tail),
        .ov_index(ov_index), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / RAM model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int a = 0; a < (1 << BWID_ADDR); a++) mem[a] = BWID'(3 * a);
    end

    always @(posedge clk) begin
        if (o_rden) iv_rddata <= mem[ov_rdaddr];
    end

    // ---------------- scoreboard / monitor ----------------
    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", nm, cyc, act, exp);
        end
    endfunction

    int          st_cnt = 0;
    logic [15:0] st_mx = '0, st_mn = '0;
    int          fr_total = 0;
    logic [15:0] fr_mx = '0, fr_mn = '0;

    always @(negedge clk) begin
        if (o_rden) begin
            if (rd_q.size() == 0) check("rden_unexpected", 64'(o_rden), 64'd0);
            else check("read", 64'({cyc, ov_rdaddr}), 64'(rd_q.pop_front()));
        end
        if (o_nd) begin
            check("head_tail_excl", 64'(o_head & o_tail), 64'd0);
            if (beat_q.size() == 0) check("nd_unexpected", 64'(o_nd), 64'd0);
            else check("beat", 64'({cyc, ov_index, o_head, o_tail, ov_data}), 64'(beat_q.pop_front()));
            if (o_head) begin
                st_cnt = 1; st_mx = ov_data; st_mn = ov_data;
            end else begin
                st_cnt++;
                if (ov_data > st_mx) st_mx = ov_data;
                if (ov_data < st_mn) st_mn = ov_data;
            end
            if (o_tail) begin
                fr_total = st_cnt; fr_mx = st_mx; fr_mn = st_mn;
            end
        end else begin
            check("idle_outputs", 64'({o_head, o_tail, ov_index}), 64'd0);
        end
        if (o_done) begin
            if (done_q.size() == 0) check("done_unexpected", 64'(o_done), 64'd0);
            else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        end
        if (o_err) begin
            if (err_q.size() == 0) check("err_unexpected", 64'(o_err), 64'd0);
            else check("err_cycle", 64'(cyc), 64'(err_q.pop_front()));
        end
        if (busy_q.size() > 0 && int'(busy_q[0][32:1]) == cyc)
            check("busy", 64'(o_busy), 64'(busy_q.pop_front() & 33'd1));
        if (zero_q.size() > 0 && zero_q[0] == cyc) begin
            void'(zero_q.pop_front());
            check("reset_outputs", 64'({o_rden, ov_rdaddr, o_nd, o_head, o_tail, ov_data,
                                       ov_index, o_busy, o_done, o_err}), 64'd0);
        end
        if (stat_q.size() > 0 && stat_q[0].cyc == cyc) begin
            stat_t st;
            st = stat_q.pop_front();
            check("frame_total", 64'(fr_total), 64'(st.total));
            check("frame_max", 64'(fr_mx), 64'(st.mx));
            check("frame_min", 64'(fr_mn), 64'(st.mn));
        end
        if (finish_req && !report_done) begin
            check("left_reads", 64'(rd_q.size()), 64'd0);
            check("left_beats", 64'(beat_q.size()), 64'd0);
            check("left_dones", 64'(done_q.size()), 64'd0);
            check("left_errs", 64'(err_q.size()), 64'd0);
            check("left_busy", 64'(busy_q.size() + zero_q.size() + stat_q.size()), 64'd0);
            report_done = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a one-cycle start and queues every read/beat/done expected up to cutoff
    task automatic start_frame(input logic [9:0] base, input logic [9:0] len,
                               input logic [7:0] gap, input int cutoff);
        int s, rc, bc, dc;
        logic [9:0] a;
        s = cyc;
        i_start = 1'b1;
        iv_baseaddr = base;
        iv_len = len;
        iv_gap = gap;
        if (len < 10'd2) begin
            err_q.push_back(s + 1);
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                rc = s + 1 + i * (int'(gap) + 1);
                bc = rc + 2;
                a = BWID_ADDR'(int'(base) + i);
                if (rc <= cutoff) rd_q.push_back({rc, a});
                if (bc <= cutoff)
                    beat_q.push_back({bc, BWID_INDEX'(i), (i == 0), (i == int'(len) - 1),
                                      BWID'(3 * int'(a))});
            end
            dc = s + 3 + (int'(len) - 1) * (int'(gap) + 1) + 1;
            if (dc <= cutoff) done_q.push_back(dc);
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
        iv_baseaddr = BWID_ADDR'($urandom_range(0, 1023));
        iv_len = BWID_INDEX'($urandom_range(0, 1023));
        iv_gap = 8'($urandom_range(0, 255));
    endtask

    task automatic poke_start();
        i_start = 1'b1;
        iv_len = 10'd5;
        iv_baseaddr = 10'h2A0;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s;
        zero_q.push_back(2);
        wait_to(3);
        rst = 1'b0;

        // basic frame, gap 0
        wait_to(5);
        s = cyc;
        busy_q.push_back({33'(s + 1) << 1 | 33'd1});
        busy_q.push_back({33'(s + 7) << 1});
        start_frame(10'h010, 10'd4, 8'd0, NEVER);
        wait_to(s + 10);

        // gap 2
        s = cyc;
        busy_q.push_back({33'(s + 9) << 1 | 33'd1});
        busy_q.push_back({33'(s + 10) << 1});
        start_frame(10'h020, 10'd3, 8'd2, NEVER);
        wait_to(s + 14);

        // rejected lengths
        s = cyc;
        busy_q.push_back({33'(s + 1) << 1});
        start_frame(10'h030, 10'd1, 8'd0, NEVER);
        wait_to(s + 3);
        s = cyc;
        busy_q.push_back({33'(s + 1) << 1});
        start_frame(10'h030, 10'd0, 8'd0, NEVER);
        wait_to(s + 4);

        // address wrap
        s = cyc;
        start_frame(10'h3FE, 10'd4, 8'd0, NEVER);
        wait_to(s + 10);

        // reset in cycle 5 of an 8-sample frame, then a clean frame
        s = cyc;
        start_frame(10'h040, 10'd8, 8'd0, s + 5);
        wait_to(s + 5);
        rst = 1'b1;
        zero_q.push_back(s + 6);
        wait_to(s + 6);
        rst = 1'b0;
        wait_to(s + 8);
        s = cyc;
        start_frame(10'h050, 10'd8, 8'd0, NEVER);
        wait_to(s + 14);

        // starts while busy are ignored; start on o_done is accepted
        s = cyc;
        start_frame(10'h100, 10'd4, 8'd0, NEVER);
        wait_to(s + 2);
        poke_start();
        wait_to(s + 4);
        poke_start();
        wait_to(s + 7);
        stat_q.push_back('{cyc: s + 7, total: 4, mx: 16'h0309, mn: 16'h0300});
        start_frame(10'h005, 10'd2, 8'd1, NEVER);
        wait_to(s + 20);

        finish_req = 1'b1;
        repeat (3) @(negedge clk);
        if (!report_done) begin
            $display("FAIL report_timeout: got 0, required 1");
            n_fail++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
